// File: rtl/sid_audio_i2s_if.sv
// sid_audio_i2s_if
//   Bundles the SID audio consumer's sample stream and I2S outputs.
//   master : drives the input sample stream (ce_1m, audio_in, mute) and
//            observes the decimated PCM and the I2S lines.
//   slave  : the sid_audio_i2s block itself.
//   Signals:
//     ce_1m         input-sample strobe, one clk wide
//     audio_in      unsigned 18-bit SID output, mid-scale 0x20000
//     mute          forces the PCM result to zero
//     sample_out    last decimated signed 16-bit PCM sample
//     sample_strobe one-cycle pulse when sample_out updates
//     overrun       one-cycle pulse when a pending sample is overwritten
//     i2s_bclk      bit clock
//     i2s_lrclk     word select, 0 = left, 1 = right
//     i2s_data      serial data, MSB first, changes on bclk falling edge
interface sid_audio_i2s_if;
  logic        ce_1m;
  logic [17:0] audio_in;
  logic        mute;
  logic [15:0] sample_out;
  logic        sample_strobe;
  logic        overrun;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_data;

  modport master (
    output ce_1m, audio_in, mute,
    input  sample_out, sample_strobe, overrun, i2s_bclk, i2s_lrclk, i2s_data
  );

  modport slave (
    input  ce_1m, audio_in, mute,
    output sample_out, sample_strobe, overrun, i2s_bclk, i2s_lrclk, i2s_data
  );
endinterface

// File: rtl/sid_audio_i2s.sv
// sid_audio_i2s
//   Consumes the ~1 MHz unsigned SID audio stream, boxcar-averages
//   2^DECIM_LOG2 samples, removes the mid-scale offset to give signed
//   16-bit PCM, and serialises it as mono-duplicated I2S. The decimator
//   and the I2S framer run from independent counters and meet in a
//   one-entry holding register.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-low (0 = reset)
//     bus    sid_audio_i2s_if.slave: sample stream in, PCM and I2S out
module sid_audio_i2s #(
  parameter int DECIM_LOG2 = 5,
  parameter int BCLK_DIV   = 8
) (
  input  logic            clk,
  input  logic            reset,
  sid_audio_i2s_if.slave  bus
);

  localparam int ACC_W = 18 + DECIM_LOG2;
  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  // Offset removal and truncation to 16 bits (floor, drops 2 LSBs).
  function automatic logic signed [15:0] to_pcm(input logic [17:0] avg);
    logic signed [17:0] s18;
    s18 = $signed(avg - 18'h20000);
    return $signed(s18[17:2]);
  endfunction

  logic [ACC_W-1:0]      acc;
  logic [DECIM_LOG2-1:0] cnt;
  logic [ACC_W-1:0]      sum;
  logic [17:0]           avg;

  logic signed [15:0]    pcm_p1;
  logic                  vld_p1;

  logic signed [15:0]    hold_p2;
  logic                  pending_p2;
  logic                  ovr_p2;

  logic [DIV_W-1:0]      div;
  logic                  bclk;
  logic                  lrclk;
  logic                  sdata;
  logic [4:0]            slot;
  logic [4:0]            slot_nx;
  logic [31:0]           frame;
  logic                  bclk_fall;
  logic                  frame_load;

  always_comb begin
    sum = acc + ACC_W'(bus.audio_in);
    avg = sum[ACC_W-1:DECIM_LOG2];
  end

  // Stage p0 -> p1: accumulate and emit one averaged PCM sample per window
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc    <= '0;
      cnt    <= '0;
      pcm_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (bus.ce_1m) begin
        cnt <= cnt + DECIM_LOG2'(1);
        if (&cnt) begin
          acc    <= '0;
          pcm_p1 <= bus.mute ? 16'sd0 : to_pcm(avg);
          vld_p1 <= 1'b1;
        end else begin
          acc <= sum;
        end
      end
    end
  end

  // The bit clock falls when the divider wraps while bclk is high.
  // Slot 0 is where a new frame is taken from the holding register.
  assign bclk_fall  = bclk && (div == DIV_LAST);
  assign slot_nx    = slot + 5'd1;
  assign frame_load = bclk_fall && (slot_nx == 5'd0);

  // Stage p1 -> p2: holding register and I2S framer
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_p2    <= '0;
      pending_p2 <= 1'b0;
      ovr_p2     <= 1'b0;
      div        <= '0;
      bclk       <= 1'b0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      slot       <= 5'd31;
      frame      <= '0;
    end else begin
      if (div == DIV_LAST) begin
        div  <= '0;
        bclk <= ~bclk;
      end else begin
        div <= div + DIV_W'(1);
      end

      // One-slot I2S delay: slot s carries frame bit (32 - s) mod 32, so
      // slot 0 shifts out bit 0 of the frame that is being replaced.
      if (bclk_fall) begin
        slot  <= slot_nx;
        lrclk <= slot_nx[4];
        sdata <= frame[5'd0 - slot_nx];
        if (slot_nx == 5'd0) begin
          frame <= {hold_p2, hold_p2};
        end
      end

      // A strobe coincident with the frame load refills the slot the load
      // just emptied, so it is not an overrun.
      ovr_p2 <= vld_p1 && pending_p2 && !frame_load;
      if (vld_p1) begin
        hold_p2    <= pcm_p1;
        pending_p2 <= 1'b1;
      end else if (frame_load) begin
        pending_p2 <= 1'b0;
      end
    end
  end

  assign bus.sample_out    = pcm_p1;
  assign bus.sample_strobe = vld_p1;
  assign bus.overrun       = ovr_p2;
  assign bus.i2s_bclk      = bclk;
  assign bus.i2s_lrclk     = lrclk;
  assign bus.i2s_data      = sdata;

endmodule

// File: tb/tb_sid_audio_i2s.sv
// tb_sid_audio_i2s
//   Drives sid_audio_i2s with directed and randomised sample streams and
//   checks PCM values, strobe timing, overrun pulses and the decoded I2S
//   words against a behavioural model kept in this bench.
module tb_sid_audio_i2s;
  localparam int DECIM_LOG2 = 5;
  localparam int BCLK_DIV   = 8;
  localparam int WIN        = 1 << DECIM_LOG2;
  localparam int FRAME_CLK  = 64 * BCLK_DIV;

  logic clk = 1'b0;
  logic reset = 1'b0;

  sid_audio_i2s_if bus();

  sid_audio_i2s #(
    .DECIM_LOG2 (DECIM_LOG2),
    .BCLK_DIV   (BCLK_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // cycle index of the most recent rising edge and the reset level it saw
  int   cyc = 0;
  logic rst_smp = 1'b0;
  initial forever begin
    @(posedge clk);
    cyc++;
    rst_smp = reset;
  end

  // Decimator model: plain window sum, average, offset removal, floor /4.
  int          win_sum = 0;
  int          win_cnt = 0;
  logic [15:0] exp_val_q[$];
  int          exp_cyc_q[$];

  // Monitor / receiver state visible to the stimulus process
  int          slot_i = 31;
  int          loads = 0;
  int          ovr_seen = 0;
  logic [15:0] last_left = '0;
  logic [15:0] last_right = '0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [17:0] a, input int gap);
    int avg, s, pcm;
    bus.ce_1m    = 1'b1;
    bus.audio_in = a;
    win_sum += int'(a);
    win_cnt++;
    if (win_cnt == WIN) begin
      avg = win_sum / WIN;
      s   = avg - 131072;
      pcm = (s - (((s % 4) + 4) % 4)) / 4;
      exp_val_q.push_back(bus.mute ? 16'h0000 : 16'(pcm));
      exp_cyc_q.push_back(cyc + 1);
      win_sum = 0;
      win_cnt = 0;
    end
    tick(1);
    bus.ce_1m = 1'b0;
    tick(gap);
  endtask

  task automatic wait_load();
    int l0, t;
    l0 = loads;
    t  = 0;
    while (loads == l0 && t < 2 * FRAME_CLK) begin
      tick(1);
      t++;
    end
    check("wait_load", 32'(loads != l0), 32'd1);
  endtask

  task automatic wait_slot(input int s);
    int t;
    t = 0;
    while (slot_i != s && t < 2 * FRAME_CLK) begin
      tick(1);
      t++;
    end
    check("wait_slot", slot_i, s);
  endtask

  // Monitor: reset values, strobes, overrun, and an I2S receiver that
  // rebuilds left/right words from the serial stream.
  initial begin : mon
    logic        in_reset, seen_fall, seen_load, load;
    logic        bclk_q, lrclk_q, data_q;
    logic        prev_stb;
    logic [15:0] prev_val, hold_m, frame_exp, last_out, left_sh, right_sh, v;
    int          right_bits, win_strobes, prev_before;
    int          rel_cyc, last_fall, last_load, ec;
    in_reset = 1'b1;
    forever begin
      @(negedge clk);
      if (cyc == 0) continue;
      if (!rst_smp) begin
        check("rst_sample_out", bus.sample_out, 32'd0);
        check("rst_strobe", bus.sample_strobe, 32'd0);
        check("rst_overrun", bus.overrun, 32'd0);
        check("rst_bclk", bus.i2s_bclk, 32'd0);
        check("rst_lrclk", bus.i2s_lrclk, 32'd0);
        check("rst_data", bus.i2s_data, 32'd0);
        in_reset = 1'b1; seen_fall = 1'b0; seen_load = 1'b0;
        bclk_q = 1'b0; lrclk_q = 1'b0; data_q = 1'b0;
        prev_stb = 1'b0; prev_val = '0; hold_m = '0; frame_exp = '0; last_out = '0;
        right_bits = 0; win_strobes = 0; prev_before = 0;
        slot_i = 31;
      end else begin
        load = 1'b0;
        if (in_reset) begin
          in_reset = 1'b0;
          rel_cyc  = cyc;
        end
        if (bclk_q && !bus.i2s_bclk) begin
          // the release edge itself is the first of the 2*BCLK_DIV counting edges
          if (!seen_fall) check("first_bclk_fall", cyc - rel_cyc, 2 * BCLK_DIV - 1);
          else            check("bclk_period", cyc - last_fall, 2 * BCLK_DIV);
          seen_fall = 1'b1;
          last_fall = cyc;
          slot_i = (slot_i + 1) % 32;
          check("lrclk_level", bus.i2s_lrclk, 32'(slot_i >= 16));
          if (slot_i == 0) begin
            if (right_bits == 15) begin
              last_right = {right_sh[14:0], bus.i2s_data};
              check("right_word", last_right, frame_exp);
            end else begin
              check("slot0_after_reset", bus.i2s_data, 32'd0);
            end
            if (seen_load) check("frame_period", cyc - last_load, FRAME_CLK);
            seen_load = 1'b1;
            last_load = cyc;
            load      = 1'b1;
            frame_exp = hold_m;
            right_bits = 0;
            loads++;
          end else if (slot_i <= 16) begin
            left_sh = {left_sh[14:0], bus.i2s_data};
            if (slot_i == 16) begin
              last_left = left_sh;
              check("left_word", last_left, frame_exp);
            end
          end else begin
            right_sh = {right_sh[14:0], bus.i2s_data};
            right_bits++;
          end
        end else begin
          check("lrclk_stable", bus.i2s_lrclk, lrclk_q);
          check("data_stable", bus.i2s_data, data_q);
        end
        bclk_q  = bus.i2s_bclk;
        lrclk_q = bus.i2s_lrclk;
        data_q  = bus.i2s_data;

        // A strobe seen last cycle is taken into the holding register now;
        // it overruns only if its window already had a sample and no load
        // happens on the same edge.
        check("overrun", bus.overrun, 32'(prev_stb && prev_before > 0 && !load));
        if (bus.overrun === 1'b1) ovr_seen++;
        if (load) win_strobes = prev_stb ? 1 : 0;
        if (prev_stb) hold_m = prev_val;

        if (bus.sample_strobe === 1'b1) begin
          check("strobe_expected", 32'(exp_val_q.size() > 0), 32'd1);
          if (exp_val_q.size() > 0) begin
            v  = exp_val_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("sample_value", bus.sample_out, v);
            check("strobe_cycle", cyc, ec);
            last_out = v;
          end
          prev_before = win_strobes;
          win_strobes++;
          prev_stb = 1'b1;
          prev_val = last_out;
        end else begin
          prev_stb = 1'b0;
          check("sample_hold", bus.sample_out, last_out);
        end
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
          check("strobe_missing_at", cyc, exp_cyc_q[0]);
          void'(exp_val_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int o0;
    bus.ce_1m    = 1'b0;
    bus.audio_in = '0;
    bus.mute     = 1'b0;
    reset        = 1'b0;
    tick(4);
    reset = 1'b1;

    // mid-scale gives zero
    repeat (WIN) send(18'h20000, 2);
    check("tp_midscale", bus.sample_out, 32'h0000);

    // full-scale extremes
    repeat (WIN) send(18'h3FFFF, 1);
    check("tp_max", bus.sample_out, 32'h7FFF);
    repeat (WIN) send(18'h00000, 1);
    check("tp_min", bus.sample_out, 32'h8000);

    // mixed window, then the same muted
    repeat (WIN / 2) send(18'h20000, 1);
    repeat (WIN / 2) send(18'h20400, 1);
    check("tp_avg", bus.sample_out, 32'h0080);
    bus.mute = 1'b1;
    repeat (WIN / 2) send(18'h20000, 1);
    repeat (WIN / 2) send(18'h20400, 1);
    check("tp_mute", bus.sample_out, 32'h0000);
    bus.mute = 1'b0;

    // 0x0970C averages to PCM 0xA5C3
    repeat (WIN) send(18'h0970C, 0);
    check("tp_a5c3", bus.sample_out, 32'hA5C3);
    wait_load();
    wait_load();
    wait_load();
    check("tp_left_a5c3", last_left, 32'hA5C3);
    check("tp_right_a5c3", last_right, 32'hA5C3);

    // underrun: the same word keeps repeating, no overrun
    o0 = ovr_seen;
    tick(3 * FRAME_CLK);
    check("tp_idle_overrun", ovr_seen - o0, 32'd0);
    check("tp_idle_left", last_left, 32'hA5C3);
    check("tp_idle_right", last_right, 32'hA5C3);

    // two samples inside one frame: one overrun, newest wins
    wait_load();
    o0 = ovr_seen;
    repeat (WIN) send(18'h24444, 0);
    repeat (WIN) send(18'h28888, 0);
    tick(4);
    check("tp_overrun_count", ovr_seen - o0, 32'd1);
    wait_load();
    tick(20 * 2 * BCLK_DIV);
    check("tp_newest_wins", last_left, 32'h2222);

    // reset mid-frame with a half-full accumulator
    wait_load();
    repeat (WIN / 2) send(18'($urandom), 0);
    wait_slot(9);
    reset   = 1'b0;
    win_sum = 0;
    win_cnt = 0;
    tick(3);
    reset = 1'b1;
    repeat (WIN) send(18'($urandom), 1);
    tick(2 * FRAME_CLK);
    check("tp_post_reset_left", last_left, exp_val_q.size() == 0 ? bus.sample_out : 16'hxxxx);

    // randomised traffic: varying rates give both overruns and underruns
    repeat (40 * WIN) begin
      bus.mute = ($urandom_range(0, 7) == 0);
      send(18'($urandom), $urandom_range(0, 24));
    end
    bus.mute = 1'b0;
    tick(3 * FRAME_CLK);
    check("queue_drained", exp_val_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
